// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM slave for the core memory port.
// Accepts a cs/we/oe request, waits WAIT_STATES cycles, then pulses ready for
// one cycle with read data on data_out. Byte/halfword lanes are handled on
// both reads (zero-extended) and writes (byte enables).
// Optional feature macro: MEM_RESP_ERR_EN adds an err output that flags
// out-of-range addresses and the reserved data_size 2'b11.
//
// Handshake: a request is valid while cs & (we | oe). The request is taken on
// the first rising edge seen in IDLE; ready is high for exactly one cycle when
// the access completes. Dropping cs while waiting cancels the access.
module mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        oe,
    input  logic [31:0] address,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
`ifdef MEM_RESP_ERR_EN
    output logic        err,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        op_q, op_d;          // 1 = write
    logic [31:0] data_out_q, data_out_d;

    logic [31:0] mem [0:DEPTH-1];

    logic                 commit;
    logic                 use_in;
    logic                 acc_op;
    logic [1:0]           acc_size;
    logic [1:0]           acc_lo;
    logic [ADDR_BITS-1:0] acc_idx;
    logic [31:0]          acc_data;
    logic                 acc_bad;
    logic [31:0]          rd_word;
    logic [31:0]          rd_lane;
    logic [3:0]           be;
    logic [31:0]          wdata_rep;
    logic [31:0]          merged;
    logic                 wr_en;
`ifdef MEM_RESP_ERR_EN
    logic                 err_q, err_d;
`endif

    // Next-state logic: accept, count down, restart on address/size change, abort on cs low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs && (we || oe)) begin
                    addr_d  = address;
                    size_d  = data_size;
                    wdata_d = data_in;
                    op_d    = we;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end else if ((address != addr_q) || (data_size != size_q)) begin
                    addr_d  = address;
                    size_d  = data_size;
                    wdata_d = data_in;
                    op_d    = we;
                    cnt_d   = 4'(WAIT_STATES);
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access datapath: committed access comes from the live inputs only on a zero-wait accept.
    always_comb begin
        use_in    = (state_q == ST_IDLE);
        acc_op    = use_in ? we        : op_q;
        acc_size  = use_in ? data_size : size_q;
        acc_lo    = use_in ? address[1:0] : addr_q[1:0];
        acc_idx   = use_in ? address[ADDR_BITS+1:2] : addr_q[ADDR_BITS+1:2];
        acc_data  = use_in ? data_in   : wdata_q;
`ifdef MEM_RESP_ERR_EN
        acc_bad   = (((use_in ? address : addr_q) >> (ADDR_BITS + 2)) != 32'd0) ||
                    (acc_size == 2'b11);
`else
        acc_bad   = 1'b0;
`endif
        rd_word   = mem[acc_idx];
        be        = 4'b1111;
        wdata_rep = acc_data;
        rd_lane   = rd_word;
        case (acc_size)
            2'b00: begin
                be        = 4'b0001 << acc_lo;
                wdata_rep = {4{acc_data[7:0]}};
                rd_lane   = {24'h0, rd_word[8*acc_lo +: 8]};
            end
            2'b01: begin
                be        = acc_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{acc_data[15:0]}};
                rd_lane   = {16'h0, (acc_lo[1] ? rd_word[31:16] : rd_word[15:0])};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = acc_data;
                rd_lane   = rd_word;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wdata_rep[8*i +: 8] : rd_word[8*i +: 8];
        end
        wr_en      = commit && acc_op && !acc_bad;
        data_out_d = data_out_q;
        if (commit && !acc_op) begin
            data_out_d = acc_bad ? 32'hDEAD_BEEF : rd_lane;
        end
`ifdef MEM_RESP_ERR_EN
        err_d = commit && acc_bad;
`endif
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            wdata_q    <= 32'h0;
            op_q       <= 1'b0;
            data_out_q <= 32'h0;
`ifdef MEM_RESP_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
`ifdef MEM_RESP_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // RAM array: not reset, written only on the edge that commits a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[acc_idx] <= merged;
        end
    end

    assign data_out  = data_out_q;
    assign ready     = (state_q == ST_RESP);
    assign state_dbg = state_q;
`ifdef MEM_RESP_ERR_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder (WAIT_STATES=2, ADDR_BITS=10): directed cases
// followed by randomized accesses checked against a byte-array model.
module tb_mem_responder;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, we, oe;
    logic [31:0] address;
    logic [1:0]  data_size;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic [1:0]  state_dbg;
`ifdef MEM_RESP_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]  ref_b [0:4095];
    logic [31:0] rd;
    logic        rd_err;
    int          lat;

    mem_responder #(.ADDR_BITS(10), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .oe        (oe),
        .address   (address),
        .data_size (data_size),
        .data_in   (data_in),
        .data_out  (data_out),
        .ready     (ready),
`ifdef MEM_RESP_ERR_EN
        .err       (err),
`endif
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: 4 KB of bytes, byte address wraps modulo the RAM size.
    task automatic ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int base;
        if (sz == 2'b00) begin
            ref_b[a % 4096] = d[7:0];
        end else if (sz == 2'b01) begin
            base = (a % 4096) & ~1;
            ref_b[base]     = d[7:0];
            ref_b[base + 1] = d[15:8];
        end else begin
            base = (a % 4096) & ~3;
            for (int k = 0; k < 4; k++) ref_b[base + k] = d[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz);
        int base;
        if (sz == 2'b00) return {24'h0, ref_b[a % 4096]};
        if (sz == 2'b01) begin
            base = (a % 4096) & ~1;
            return {16'h0, ref_b[base + 1], ref_b[base]};
        end
        base = (a % 4096) & ~3;
        return {ref_b[base + 3], ref_b[base + 2], ref_b[base + 1], ref_b[base]};
    endfunction

    // Driver: one complete access, returns read data and accept-to-ready latency.
    task automatic access(input logic w, input logic both, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d,
                          output logic [31:0] rdata, output int latency);
        @(negedge clk);
        cs = 1'b1; we = w; oe = !w || both;
        address = a; data_size = sz; data_in = d;
        @(posedge clk);
        latency = 0;
        do begin
            @(posedge clk); #1;
            latency++;
        end while (!ready && latency < 20);
        rdata = data_out;
`ifdef MEM_RESP_ERR_EN
        rd_err = err;
`else
        rd_err = 1'b0;
`endif
        @(negedge clk);
        cs = 1'b0; we = 1'b0; oe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic        w, seen;
        int          pulses, first, second;

        rst = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0;
        address = 32'h0; data_size = 2'b00; data_in = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_state", {30'b0, state_dbg}, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Word write then word read at 0x40
        access(1'b1, 1'b0, 32'h40, 2'b10, 32'h1234_5678, rd, lat);
        chk("wr_latency", lat, WS + 1);
        access(1'b0, 1'b0, 32'h40, 2'b10, 32'h0, rd, lat);
        chk("rd_latency", lat, WS + 1);
        chk("rd_word_40", rd, 32'h1234_5678);

        // Byte and halfword lane writes
        access(1'b1, 1'b0, 32'h41, 2'b00, 32'hFFFF_FFAB, rd, lat);
        access(1'b1, 1'b0, 32'h42, 2'b01, 32'h1111_BEEF, rd, lat);
        access(1'b0, 1'b0, 32'h40, 2'b10, 32'h0, rd, lat);
        chk("rd_merged", rd, 32'hBEEF_AB78);

        // Narrow reads, zero-extended
        access(1'b0, 1'b0, 32'h43, 2'b00, 32'h0, rd, lat);
        chk("rd_byte_43", rd, 32'h0000_00BE);
        access(1'b0, 1'b0, 32'h41, 2'b01, 32'h0, rd, lat);
        chk("rd_half_41", rd, 32'h0000_AB78);

        // Back-to-back reads with cs/oe held high: period WS+3
        @(negedge clk);
        cs = 1'b1; we = 1'b0; oe = 1'b1; address = 32'h40; data_size = 2'b10;
        pulses = 0; first = 0; second = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                pulses++;
                if (pulses == 1) first = k;
                if (pulses == 2) second = k;
            end
        end
        chk("b2b_pulses", pulses, 3);
        chk("b2b_first", first, WS + 2);
        chk("b2b_period", second - first, WS + 3);
        chk("b2b_data", data_out, 32'hBEEF_AB78);
        @(negedge clk) cs = 1'b0; oe = 1'b0;
        @(posedge clk);

        // Address change one cycle into WAIT restarts the wait
        access(1'b1, 1'b0, 32'h44, 2'b10, 32'h5566_7788, rd, lat);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; oe = 1'b1; address = 32'h40; data_size = 2'b10;
        @(posedge clk);
        @(negedge clk) address = 32'h44;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 20);
        chk("restart_latency", lat, WS + 1);
        chk("restart_data", data_out, 32'h5566_7788);
        @(negedge clk) cs = 1'b0; oe = 1'b0;

        // Reset in the middle of a write's wait
        access(1'b1, 1'b0, 32'h10, 2'b10, 32'h1111_2222, rd, lat);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'h10; data_size = 2'b10;
        data_in = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cs = 1'b0; we = 1'b0;
        #1;
        chk("midrst_state", {30'b0, state_dbg}, 32'd0);
        chk("midrst_data", data_out, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        chk("midrst_no_ready", {31'b0, seen}, 32'd0);
        @(negedge clk) rst = 1'b1;
        access(1'b0, 1'b0, 32'h10, 2'b10, 32'h0, rd, lat);
        chk("midrst_kept", rd, 32'h1111_2222);

        // cs dropped during WAIT cancels the write
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'h40; data_size = 2'b10;
        data_in = 32'h9999_9999;
        @(posedge clk);
        @(negedge clk) cs = 1'b0; we = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        chk("abort_no_ready", {31'b0, seen}, 32'd0);
        access(1'b0, 1'b0, 32'h40, 2'b10, 32'h0, rd, lat);
        chk("abort_kept", rd, 32'hBEEF_AB78);

        // we and oe both high is a write
        access(1'b1, 1'b1, 32'h48, 2'b10, 32'h0BAD_F00D, rd, lat);
        chk("both_latency", lat, WS + 1);
        access(1'b0, 1'b0, 32'h48, 2'b10, 32'h0, rd, lat);
        chk("both_is_write", rd, 32'h0BAD_F00D);

        // Out-of-range address
        access(1'b1, 1'b0, 32'h0, 2'b10, 32'h1357_9BDF, rd, lat);
        access(1'b0, 1'b0, 32'h1000, 2'b10, 32'h0, rd, lat);
`ifdef MEM_RESP_ERR_EN
        chk("oor_data", rd, 32'hDEAD_BEEF);
        chk("oor_err", {31'b0, rd_err}, 32'd1);
`else
        chk("oor_alias", rd, 32'h1357_9BDF);
        // Reserved size acts as a word access
        access(1'b1, 1'b0, 32'h4D, 2'b11, 32'hA5C3_5A3C, rd, lat);
        access(1'b0, 1'b0, 32'h4E, 2'b11, 32'h0, rd, lat);
        chk("size11_word", rd, 32'hA5C3_5A3C);
`endif

        // Randomized accesses in 0x100..0x13F against the byte model
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            a = 32'h100 + 32'(4 * k);
            access(1'b1, 1'b0, a, 2'b10, d, rd, lat);
            ref_write(a, 2'b10, d);
        end
        for (int k = 0; k < 48; k++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
`ifdef MEM_RESP_ERR_EN
            sz = 2'($urandom_range(0, 2));
`else
            sz = 2'($urandom_range(0, 3));
`endif
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            access(w, 1'b0, a, sz, d, rd, lat);
            chk("rand_latency", lat, WS + 1);
            if (w) ref_write(a, sz, d);
            else   chk("rand_read", rd, ref_read(a, sz));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
